sipo_aligner: RTL and testbench

SIPO_ALIGNER -- requirements
Module: sipo_aligner

---
 rtl/sipo_aligner.sv | 159 +++++++++++++++
 tb/tb_sipo_aligner.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sipo_aligner.sv
// rtl/sipo_aligner.sv - serial-to-parallel deserialiser with comma word alignment
// Define COMMA_ALIGN_EN to build the comma aligner; otherwise words are framed from reset release.
module sipo_aligner #(
    parameter int unsigned WIDTH      = 10,
    parameter logic [31:0] COMMA      = 32'h0000_017C,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned ERR_LIMIT  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             valid,
    output logic             locked
);
    localparam int unsigned     CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   ONE  = CW'(1);

    if (WIDTH < 4 || WIDTH > 32 || LOCK_COUNT < 1 || LOCK_COUNT > 15 ||
        ERR_LIMIT < 1 || ERR_LIMIT > 15 || COMMA[WIDTH-1:0] == {WIDTH{1'b0}}) begin : g_bad_param
        $error("sipo_aligner: parameter out of range");
    end

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_pout;
    logic             r_valid;
    logic             r_locked;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_window;
    logic             w_boundary;

    assign w_window     = {s_in, r_sr[WIDTH-1:1]};
    assign parallel_out = r_pout;
    assign valid        = r_valid;
    assign locked       = r_locked;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_window;
        end
    end

`ifdef COMMA_ALIGN_EN
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    localparam logic [WIDTH-1:0] K  = COMMA[WIDTH-1:0];
    localparam logic [3:0]       LC = 4'(LOCK_COUNT);
    localparam logic [3:0]       EL = 4'(ERR_LIMIT);

    state_t     r_state;
    logic [3:0] r_good;
    logic [3:0] r_err;
    logic       w_match;
    logic [3:0] w_good_inc;
    logic [3:0] w_err_inc;

    // Either running disparity of the comma counts as a match.
    assign w_match    = (w_window == K) || (w_window == ~K);
    assign w_boundary = (r_state != HUNT) && (r_cnt == LAST);
    assign w_good_inc = r_good + 4'd1;
    assign w_err_inc  = r_err + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= HUNT;
            r_pout   <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_cnt    <= '0;
            r_good   <= '0;
            r_err    <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_match) begin
                        r_pout  <= w_window;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        r_good  <= 4'd1;
                        r_err   <= '0;
                        if (LC == 4'd1) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end else begin
                            r_state <= SYNC;
                        end
                    end
                end
                SYNC: begin
                    r_cnt <= w_boundary ? '0 : r_cnt + ONE;
                    if (w_boundary) begin
                        r_pout  <= w_window;
                        r_valid <= 1'b1;
                    end
                    if (w_match && w_boundary) begin
                        r_good <= w_good_inc;
                        if (w_good_inc >= LC) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                            r_err    <= '0;
                        end
                    end else if (w_match) begin
                        // Comma off the current framing: restart framing on it.
                        r_pout  <= w_window;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        r_good  <= 4'd1;
                    end
                end
                LOCKED: begin
                    r_cnt <= w_boundary ? '0 : r_cnt + ONE;
                    if (w_boundary) begin
                        r_pout  <= w_window;
                        r_valid <= 1'b1;
                    end
                    if (w_match && w_boundary) begin
                        r_err <= '0;
                    end else if (w_match) begin
                        if (w_err_inc >= EL) begin
                            r_state  <= HUNT;
                            r_locked <= 1'b0;
                            r_cnt    <= '0;
                            r_good   <= '0;
                            r_err    <= '0;
                        end else begin
                            r_err <= w_err_inc;
                        end
                    end
                end
                default: r_state <= HUNT;
            endcase
        end
    end
`else
    assign w_boundary = (r_cnt == LAST);

    // Free-running framing: first boundary lands WIDTH clocks after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pout   <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_valid <= w_boundary;
            r_cnt   <= w_boundary ? '0 : r_cnt + ONE;
            if (w_boundary) begin
                r_pout   <= w_window;
                r_locked <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sipo_aligner.sv
// tb/tb_sipo_aligner.sv - directed self-checking bench for sipo_aligner
// Exercises the COMMA_ALIGN_EN build or the plain framing build, whichever is compiled.
module tb_sipo_aligner;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_in = 1'b0;
    logic [9:0] parallel_out;
    logic       valid;
    logic       locked;

    int n_checks = 0;
    int n_fail   = 0;

    sipo_aligner #(
        .WIDTH      (10),
        .COMMA      (32'h0000_017C),
        .LOCK_COUNT (3),
        .ERR_LIMIT  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_in         (s_in),
        .parallel_out (parallel_out),
        .valid        (valid),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        s_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic outs_zero(input string tag);
        check({tag, "_po"}, 32'(parallel_out), 32'd0);
        check({tag, "_v"}, 32'(valid), 32'd0);
        check({tag, "_lk"}, 32'(locked), 32'd0);
    endtask

    // Sends one 10-bit word LSB first; checks valid on every bit, data where valid is due,
    // and locked after the last bit.
    task automatic send_word(input string tag, input logic [9:0] w,
                             input logic v8, input logic [9:0] p8,
                             input logic v9, input logic [9:0] p9, input logic lk);
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i]);
            check({tag, "_v"}, 32'(valid), 32'd0);
        end
        send_bit(w[8]);
        check({tag, "_v8"}, 32'(valid), 32'(v8));
        if (v8) check({tag, "_po8"}, 32'(parallel_out), 32'(p8));
        send_bit(w[9]);
        check({tag, "_v9"}, 32'(valid), 32'(v9));
        if (v9) check({tag, "_po9"}, 32'(parallel_out), 32'(p9));
        check({tag, "_lk"}, 32'(locked), 32'(lk));
    endtask

`ifndef COMMA_ALIGN_EN
    task automatic first_word(input string tag, input logic [9:0] w);
        for (int i = 0; i < 9; i++) begin
            send_bit(w[i]);
            check({tag, "_v"}, 32'(valid), 32'd0);
            check({tag, "_lk"}, 32'(locked), 32'd0);
        end
        send_bit(w[9]);
        check({tag, "_v9"}, 32'(valid), 32'd1);
        check({tag, "_po9"}, 32'(parallel_out), 32'(w));
        check({tag, "_lk9"}, 32'(locked), 32'd1);
    endtask
`endif

    initial begin
        reset = 1'b0;
        s_in  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            outs_zero("rst_hold");
        end
        reset = 1'b1;

`ifdef COMMA_ALIGN_EN
        send_bit(1'b1); check("pre_v", 32'(valid), 32'd0);
        send_bit(1'b0); check("pre_v", 32'(valid), 32'd0);
        send_bit(1'b1); check("pre_v", 32'(valid), 32'd0);
        send_word("acq0", 10'h17C, 1'b0, 10'h000, 1'b1, 10'h17C, 1'b0);
        send_word("acq1", 10'h0AA, 1'b0, 10'h000, 1'b1, 10'h0AA, 1'b0);
        send_word("acq2", 10'h17C, 1'b0, 10'h000, 1'b1, 10'h17C, 1'b0);
        send_word("acq3", 10'h283, 1'b0, 10'h000, 1'b1, 10'h283, 1'b1);

        // One-bit slip: old framing now lands one bit early on every comma.
        send_bit(1'b0);
        check("slip_v", 32'(valid), 32'd0);
        check("slip_lk", 32'(locked), 32'd1);
        send_word("slip1", 10'h17C, 1'b1, 10'h2F8, 1'b0, 10'h000, 1'b1);
        send_word("slip2", 10'h17C, 1'b1, 10'h2F8, 1'b0, 10'h000, 1'b1);
        send_word("slip3", 10'h17C, 1'b1, 10'h2F8, 1'b0, 10'h000, 1'b1);
        send_word("slip4", 10'h17C, 1'b1, 10'h2F8, 1'b0, 10'h000, 1'b0);
        send_word("relock0", 10'h17C, 1'b0, 10'h000, 1'b1, 10'h17C, 1'b0);
        send_word("relock1", 10'h17C, 1'b0, 10'h000, 1'b1, 10'h17C, 1'b0);
        send_word("relock2", 10'h17C, 1'b0, 10'h000, 1'b1, 10'h17C, 1'b1);

        for (int i = 0; i < 4; i++) send_bit(1'b0 ^ (i % 2 == 1));
        reset = 1'b0;
        #1;
        outs_zero("async_rst");
        @(posedge clk);
        #1;
        outs_zero("rst_pulse");
        reset = 1'b1;

        for (int k = 0; k < 20; k++) begin
            send_word("nocomma", 10'h0AA, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0);
            check("nocomma_po", 32'(parallel_out), 32'd0);
        end
        send_word("resume", 10'h17C, 1'b0, 10'h000, 1'b1, 10'h17C, 1'b0);
`else
        first_word("free0", 10'h155);
        send_word("free1", 10'h155, 1'b0, 10'h000, 1'b1, 10'h155, 1'b1);
        send_word("free2", 10'h155, 1'b0, 10'h000, 1'b1, 10'h155, 1'b1);
        send_word("free3", 10'h3A5, 1'b0, 10'h000, 1'b1, 10'h3A5, 1'b1);
        send_word("free4", 10'h001, 1'b0, 10'h000, 1'b1, 10'h001, 1'b1);
        send_word("free5", 10'h2C3, 1'b0, 10'h000, 1'b1, 10'h2C3, 1'b1);

        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b0;
        #1;
        outs_zero("async_rst");
        @(posedge clk);
        #1;
        outs_zero("rst_pulse");
        reset = 1'b1;
        first_word("after_rst", 10'h2C3);
        send_word("after_rst1", 10'h0F0, 1'b0, 10'h000, 1'b1, 10'h0F0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
